fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end. Issues sequential fetch
// requests under a credit limit, buffers returning instructions with their
// PCs, and on a redirect flushes the buffer and discards stale responses.

module fetch_unit #(
  parameter int                DWIDTH         = 32,
  parameter int                AWIDTH         = 32,
  parameter logic [31:0]       IMEM_BASE_ADDR = 32'h0000_1000,
  parameter logic [AWIDTH-1:0] RESET_PC       = AWIDTH'(IMEM_BASE_ADDR),
  parameter int                DEPTH          = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcsel_i,
  input  logic [AWIDTH-1:0] pcbranch_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);

  logic [AWIDTH-1:0] r_fetchPc;
  logic [AWIDTH-1:0] r_rspPc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_dropCnt;
  logic [CW-1:0]     r_wrPtr;
  logic [CW-1:0]     r_rdPtr;
  logic [DWIDTH-1:0] r_bufInsn [DEPTH];
  logic [AWIDTH-1:0] r_bufPc   [DEPTH];

  logic [CW-1:0]     w_occupancy;
  logic [CW:0]       w_committed;
  logic [AWIDTH-1:0] w_target;
  logic              w_reqFire;
  logic              w_dropping;
  logic              w_push;
  logic              w_pop;
  logic              w_bufEmpty;

  // Masking the low bits (rather than slicing) keeps the redirect target word aligned.
  assign w_target    = pcbranch_i & ~AWIDTH'(3);
  assign w_occupancy = r_wrPtr - r_rdPtr;
  assign w_committed = {1'b0, w_occupancy} + {1'b0, r_outstanding};
  assign w_bufEmpty  = (w_occupancy == '0);
  assign w_dropping  = (r_dropCnt != '0);

  // Gating with rst forces the request low the moment reset asserts.
  assign imem_req_valid_o = rst && !pcsel_i && (w_committed < CREDIT_LIMIT);
  assign imem_req_addr_o  = r_fetchPc;
  assign w_reqFire        = imem_req_valid_o && imem_req_ready_i;

  assign w_push = imem_rsp_valid_i && !pcsel_i && !w_dropping;
  assign w_pop  = !w_bufEmpty && insn_ready_i && !pcsel_i;

  assign insn_valid_o = !w_bufEmpty;
  assign pc_o         = w_bufEmpty ? '0 : r_bufPc[r_rdPtr[PW-1:0]];
  assign insn_o       = w_bufEmpty ? '0 : r_bufInsn[r_rdPtr[PW-1:0]];

  // Next request address: redirect target wins, else step by one word per handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetchPc <= RESET_PC;
    end else if (pcsel_i) begin
      r_fetchPc <= w_target;
    end else if (w_reqFire) begin
      r_fetchPc <= r_fetchPc + AWIDTH'(4);
    end
  end

  // PC of the next kept response; kept responses form a contiguous run from the last redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rspPc <= RESET_PC;
    end else if (pcsel_i) begin
      r_rspPc <= w_target;
    end else if (w_push) begin
      r_rspPc <= r_rspPc + AWIDTH'(4);
    end
  end

  // Requests accepted by memory whose response has not yet returned (stale ones included).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outstanding <= '0;
    end else if (w_reqFire && !imem_rsp_valid_i) begin
      r_outstanding <= r_outstanding + CW'(1);
    end else if (!w_reqFire && imem_rsp_valid_i) begin
      r_outstanding <= r_outstanding - CW'(1);
    end
  end

  // Number of in-flight responses that belong to a superseded fetch stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dropCnt <= '0;
    end else if (pcsel_i) begin
      r_dropCnt <= r_outstanding - CW'(imem_rsp_valid_i);
    end else if (imem_rsp_valid_i && w_dropping) begin
      r_dropCnt <= r_dropCnt - CW'(1);
    end
  end

  // Buffer pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (pcsel_i) begin
      r_rdPtr <= r_wrPtr;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + CW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + CW'(1);
    end
  end

  // Buffer storage needs no reset since empty entries are never visible on the outputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_bufInsn[r_wrPtr[PW-1:0]] <= imem_rsp_data_i;
      r_bufPc[r_wrPtr[PW-1:0]]   <= r_rspPc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit with a latency-configurable in-order
// memory and compares against an epoch-tagged stream model every cycle.

module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic        rdy;
    logic        pop;
    logic        expReqValid;
    logic [31:0] expReqAddr;
    logic        expInsnValid;
    logic [31:0] expPc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcsel = 1'b0;
  logic [31:0] pcbranch = '0;
  logic        reqValid;
  logic        reqReady = 1'b0;
  logic [31:0] reqAddr;
  logic        rspValid = 1'b0;
  logic [31:0] rspData = '0;
  logic        insnValid;
  logic        insnReady = 1'b0;
  logic [31:0] pcOut;
  logic [31:0] insnOut;

  logic        pcsel2 = 1'b0;
  logic [31:0] pcbranch2 = '0;
  logic        reqValid2;
  logic        reqReady2 = 1'b1;
  logic [31:0] reqAddr2;
  logic        rspValid2 = 1'b0;
  logic [31:0] rspData2 = '0;
  logic        insnValid2;
  logic        insnReady2 = 1'b1;
  logic [31:0] pcOut2;
  logic [31:0] insnOut2;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int mEpoch = 0;
  int lastDue = 0;
  logic [31:0] mFetchPc = RESET_PC;
  logic [31:0] modelQ[$];
  req_t        inflight[$];

  logic        mSel, mRdy, mPop, mRspNow, mExpReqValid, mExpInsnValid;
  logic [31:0] mTgt;

  initial forever #5 clk = ~clk;

  fetch_unit #(.DWIDTH(32), .AWIDTH(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pcsel_i(pcsel), .pcbranch_i(pcbranch),
    .imem_req_valid_o(reqValid), .imem_req_ready_i(reqReady), .imem_req_addr_o(reqAddr),
    .imem_rsp_valid_i(rspValid), .imem_rsp_data_i(rspData),
    .insn_valid_o(insnValid), .insn_ready_i(insnReady), .pc_o(pcOut), .insn_o(insnOut)
  );

  fetch_unit #(.DWIDTH(32), .AWIDTH(32), .RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dutWrap (
    .clk(clk), .rst(rst), .pcsel_i(pcsel2), .pcbranch_i(pcbranch2),
    .imem_req_valid_o(reqValid2), .imem_req_ready_i(reqReady2), .imem_req_addr_o(reqAddr2),
    .imem_rsp_valid_i(rspValid2), .imem_rsp_data_i(rspData2),
    .insn_valid_o(insnValid2), .insn_ready_i(insnReady2), .pc_o(pcOut2), .insn_o(insnOut2)
  );

  // Instruction word the memory returns for a given address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle's inputs (entered just after a rising edge) and check against the model.
  task automatic applyStimulus(input logic sel, input logic [31:0] tgt, input logic rdy, input logic pop);
    logic [31:0] expPc;
    mSel = sel; mTgt = tgt; mRdy = rdy; mPop = pop;
    pcsel = sel; pcbranch = tgt; reqReady = rdy; insnReady = pop;
    mRspNow = 1'b0;
    rspValid = 1'b0;
    rspData = '0;
    if (inflight.size() > 0) begin
      if (inflight[0].due <= cyc) begin
        mRspNow = 1'b1;
        rspValid = 1'b1;
        rspData = memWord(inflight[0].addr);
      end
    end
    #1;
    mExpReqValid  = !sel && ((modelQ.size() + inflight.size()) < DEPTH);
    mExpInsnValid = (modelQ.size() > 0);
    expPc = mExpInsnValid ? modelQ[0] : 32'h0;
    checkOutput("reqValid", 32'(reqValid), 32'(mExpReqValid));
    checkOutput("reqAddr", reqAddr, mFetchPc);
    checkOutput("insnValid", 32'(insnValid), 32'(mExpInsnValid));
    checkOutput("pcOut", pcOut, expPc);
    checkOutput("insnOut", insnOut, mExpInsnValid ? memWord(expPc) : 32'h0);
  endtask

  // Clock edge: update the stream model; responses from an older epoch are stale.
  task automatic advanceCycle(input int latMin, input int latMax);
    req_t e;
    int   due;
    @(posedge clk);
    if (mRspNow) begin
      e = inflight.pop_front();
      if (e.epoch == mEpoch && !mSel) modelQ.push_back(e.addr);
    end
    if (!mSel && mPop && mExpInsnValid) void'(modelQ.pop_front());
    if (mSel) begin
      modelQ.delete();
      mEpoch++;
      mFetchPc = mTgt & ~32'h3;
    end else if (mExpReqValid && mRdy) begin
      due = cyc + int'($urandom_range(latMax, latMin));
      if (due <= lastDue) due = lastDue + 1;
      inflight.push_back('{mFetchPc, mEpoch, due});
      lastDue = due;
      mFetchPc = mFetchPc + 32'd4;
    end
    cyc++;
    #1;
  endtask

  // Assert reset between edges, confirm outputs clear at once, release after an edge.
  task automatic doReset();
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rstReqValid", 32'(reqValid), 32'h0);
    checkOutput("rstInsnValid", 32'(insnValid), 32'h0);
    checkOutput("rstPcOut", pcOut, 32'h0);
    checkOutput("rstInsnOut", insnOut, 32'h0);
    pcsel = 1'b0; reqReady = 1'b0; insnReady = 1'b0; rspValid = 1'b0; rspData = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc += 2;
    modelQ.delete();
    inflight.delete();
    mEpoch = 0;
    lastDue = cyc;
    mFetchPc = RESET_PC;
  endtask

  // One-cycle memory for the wrap-around instance.
  initial begin : wrapMemory
    logic        hs;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      hs = reqValid2 && reqReady2;
      a  = reqAddr2;
      @(posedge clk);
      #1;
      rspValid2 = hs;
      rspData2  = memWord(a);
    end
  end

  // Wrap-around instance: the address after 0xFFFF_FFFC must be 0.
  initial begin : wrapChecks
    @(posedge rst);
    #2;
    checkOutput("wrapReqValid0", 32'(reqValid2), 32'h1);
    checkOutput("wrapAddr0", reqAddr2, WRAP_PC);
    @(posedge clk); #2;
    checkOutput("wrapAddr1", reqAddr2, 32'h0);
    @(posedge clk); #2;
    checkOutput("wrapInsnValid", 32'(insnValid2), 32'h1);
    checkOutput("wrapPc0", pcOut2, WRAP_PC);
    checkOutput("wrapInsn0", insnOut2, memWord(WRAP_PC));
    @(posedge clk); #2;
    checkOutput("wrapPc1", pcOut2, 32'h0);
    checkOutput("wrapInsn1", insnOut2, memWord(32'h0));
  end

  initial begin : mainTest
    vec_t vecs[15];
    int   streamHits;
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'h1000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'h1004, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'h1008, 1'b1, 32'h1000};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h100C, 1'b1, 32'h1000};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h1010, 1'b1, 32'h1000};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h1010, 1'b1, 32'h1000};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h1010, 1'b1, 32'h1000};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h1010, 1'b1, 32'h1004};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'h1010, 1'b1, 32'h1004};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h1010, 1'b1, 32'h1004};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h1014, 1'b1, 32'h1004};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h1014, 1'b1, 32'h1004};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h1014, 1'b1, 32'h1008};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 32'h1018, 1'b1, 32'h100C};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 32'h101C, 1'b1, 32'h1010};

    doReset();

    // Fill to the credit limit, stall, then release one slot at a time.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 32'h0, vecs[i].rdy, vecs[i].pop);
      checkOutput($sformatf("vec%0d_reqValid", i), 32'(reqValid), 32'(vecs[i].expReqValid));
      checkOutput($sformatf("vec%0d_reqAddr", i), reqAddr, vecs[i].expReqAddr);
      checkOutput($sformatf("vec%0d_insnValid", i), 32'(insnValid), 32'(vecs[i].expInsnValid));
      checkOutput($sformatf("vec%0d_pc", i), pcOut, vecs[i].expPc);
      advanceCycle(1, 1);
    end

    // Streaming with a one-cycle memory: one instruction per cycle from cycle 2.
    doReset();
    streamHits = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      if (k == 2) checkOutput("streamFirstPc", pcOut, RESET_PC);
      if (k >= 2 && insnValid === 1'b1) streamHits++;
      advanceCycle(1, 1);
    end
    checkOutput("streamThroughput", 32'(streamHits), 32'd18);

    // Redirect with two requests outstanding at three-cycle latency.
    doReset();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); advanceCycle(3, 3);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); advanceCycle(3, 3);
    applyStimulus(1'b1, 32'h2002, 1'b1, 1'b0); advanceCycle(3, 3);
    checkOutput("redirTarget", reqAddr, 32'h2000);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); advanceCycle(3, 3);
    end
    checkOutput("redirFirstValid", 32'(insnValid), 32'h1);
    checkOutput("redirFirstPc", pcOut, 32'h2000);

    // Redirect coincident with a response and a pop, followed by a second redirect.
    doReset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1); advanceCycle(1, 1);
    end
    applyStimulus(1'b1, 32'h3000, 1'b1, 1'b1); advanceCycle(1, 1);
    checkOutput("coincEmpty", 32'(insnValid), 32'h0);
    applyStimulus(1'b1, 32'h4446, 1'b1, 1'b1); advanceCycle(1, 1);
    checkOutput("b2bEmpty", 32'(insnValid), 32'h0);
    checkOutput("b2bTarget", reqAddr, 32'h4444);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); advanceCycle(1, 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); advanceCycle(1, 1);
    checkOutput("b2bFirstValid", 32'(insnValid), 32'h1);
    checkOutput("b2bFirstPc", pcOut, 32'h4444);

    // Random traffic with redirects and variable latency.
    for (int k = 0; k < 300; k++) begin
      applyStimulus($urandom_range(0, 99) < 6, $urandom, $urandom_range(0, 99) < 75,
                    $urandom_range(0, 99) < 60);
      advanceCycle(1, 4);
    end

    // Reset mid-stream, then fetch must restart at the reset PC.
    doReset();
    checkOutput("restartAddr", reqAddr, RESET_PC);
    for (int k = 0; k < 300; k++) begin
      applyStimulus($urandom_range(0, 99) < 3, $urandom, $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 80);
      advanceCycle(1, 3);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
